seq_detect_moore: RTL and testbench
===================================

SEQ_DETECT_MOORE -- requirements
Module: seq_detect_moore

Interface
REQ-001 Parameter PAT_W, default 2, pattern length in bits (>=1).
REQ-002 Parameter CNT_W, default 8, match-counter width.
REQ-003 Parameter RESET_PAT, default 2'b01, pattern loaded at reset (zero-then-one detection).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  sample enable; A consumed only on edges with en=1.
REQ-007 A  input  1  serial data bit.
REQ-008 overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 pat_load  input  1  load strobe for pat_in.
REQ-010 pat_in  input  PAT_W  new pattern; bit PAT_W-1 is the first bit received.
REQ-011 cnt_clr  input  1  clears match counter.
REQ-012 Y  output  1  Moore match flag, decoded from state only.
REQ-013 match_cnt  output  CNT_W  saturating count of detected matches.

Function
REQ-014 State SHALL comprise pattern register, PAT_W-bit history shift register, fill count 0..PAT_W, and FSM state FILL/ARMED/MATCH.
REQ-015 On an edge with en=1, history SHALL shift left with A entering bit 0; fill increments, saturating at PAT_W.
REQ-016 A match SHALL be detected on an edge when the post-shift fill equals PAT_W and the post-shift history equals the pattern register.
REQ-017 Transitions: FILL->ARMED when fill reaches PAT_W without match; any state->MATCH on detection; MATCH->ARMED (overlap=1) or MATCH->FILL with fill=0 (overlap=0) on next sampling edge without detection.
REQ-018 With overlap=0, fill SHALL reset to 0 on the detecting edge so no matched bit is reused; with overlap=1, fill stays PAT_W.
REQ-019 Y SHALL be 1 iff state is MATCH; latency is exactly one clock: Y rises in the cycle after the edge sampling the final pattern bit.
REQ-020 Back-to-back detections SHALL keep Y high continuously, one count per detecting edge.
REQ-021 With en=0, all state SHALL hold, including Y; no count increment.
REQ-022 match_cnt SHALL increment by 1 on each detecting edge and saturate at 2^CNT_W-1.
REQ-023 cnt_clr SHALL set match_cnt to 0 on that edge; cnt_clr wins over a simultaneous detection.
REQ-024 pat_load SHALL latch pat_in, set fill=0, state=FILL, Y=0 on that edge, ignoring A and en; match_cnt unaffected.
REQ-025 overlap changes SHALL take effect from the next sampling edge.
REQ-026 PAT_W=1 SHALL be supported: every sampled bit equal to the pattern is a detection.

Reset
REQ-027 On reset=1 at a rising edge: pattern=RESET_PAT, history=0, fill=0, state=FILL, Y=0, match_cnt=0.
REQ-028 reset SHALL take priority over pat_load, cnt_clr and en, including mid-match.

Structure
REQ-029 Package seq_det_pkg SHALL hold the FSM state enum (FILL, ARMED, MATCH) and fill-count width helper ($clog2(PAT_W+1)).
REQ-030 Saturating counter SHALL be a sub-module sat_counter (CNT_W, inc, clr, sync reset).

Verification
REQ-031 PAT_W=2, pat 01, overlap=1, stream 0,1,0,0,1,1,0,1 -> Y high one cycle after samples 2, 5, 8; match_cnt=3.
REQ-032 PAT_W=3, pat 101, stream 1,0,1,0,1: overlap=1 -> detections after samples 3 and 5, cnt=2; overlap=0 -> only after sample 3, cnt=1.
REQ-033 CNT_W=2, pat 01, stream of five "01" pairs -> match_cnt sticks at 3; cnt_clr with a detecting edge -> match_cnt=0.
REQ-034 pat 01, after sampling 0 pulse pat_load with pat_in=10, then stream 1,0 -> no detection until sample 2 after load, Y high next cycle.
REQ-035 en=0 for 3 cycles while Y=1 -> Y stays 1, cnt unchanged; reset asserted while Y=1 -> next cycle Y=0, cnt=0, pattern=01.

Source files
------------

// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the Moore sequence detector:
//   state_t     - FSM state encoding (FILL, ARMED, MATCH)
//   fill_width  - width needed to hold a fill count of 0..pat_w
// -----------------------------------------------------------------------------
package seq_det_pkg;

  // FILL  : fewer than PAT_W bits collected since reset/load/non-overlap match
  // ARMED : history is full, the last edge did not match
  // MATCH : the last sampling edge completed the pattern
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ARMED = 2'd1,
    MATCH = 2'd2
  } state_t;

  // Bits needed to count from 0 up to and including pat_w.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-high reset, highest priority
//   inc   - increment request (ignored once the counter is at all-ones)
//   clr   - synchronous clear, wins over inc
//   cnt   - current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_moore.sv
// -----------------------------------------------------------------------------
// seq_detect_moore
// Moore-style serial pattern detector with a runtime-loadable pattern,
// selectable overlapping / non-overlapping detection and a saturating
// match counter.
// Ports:
//   clk       - clock, all state changes on the rising edge
//   reset     - synchronous active-high reset (priority over everything)
//   en        - sample enable; A is consumed only when en=1
//   A         - serial data bit
//   overlap   - 1: matched bits may be reused, 0: restart after each match
//   pat_load  - load strobe for pat_in (restarts collection, clears Y)
//   pat_in    - new pattern, bit PAT_W-1 is the first bit received
//   cnt_clr   - clear match counter (wins over a simultaneous match)
//   Y         - match flag, high for the cycle(s) after a detecting edge
//   match_cnt - saturating count of detecting edges
// -----------------------------------------------------------------------------
module seq_detect_moore
  import seq_det_pkg::*;
#(
  parameter int               PAT_W     = 2,
  parameter int               CNT_W     = 8,
  parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             A,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             Y,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               FW       = fill_width(PAT_W);
  localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_W);

  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] hist_q;
  logic [FW-1:0]    fill_q;
  state_t           state_q;

  logic [PAT_W-1:0] hist_nx;
  logic [FW-1:0]    fill_inc;
  logic             det;

  // Post-shift view of history/fill for the current edge; a match is judged
  // on these values so Y rises right after the final pattern bit is sampled.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first) so no latch is inferred.
  always_comb begin
    hist_nx  = PAT_W'({hist_q, A});
    fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
    det      = en && !pat_load && (fill_inc == FILL_MAX) && (hist_nx == pat_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q   <= RESET_PAT;
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= FILL;
    end else if (pat_load) begin
      // History is left as-is: fill=0 guarantees PAT_W fresh bits are
      // shifted in before the next comparison can succeed.
      pat_q   <= pat_in;
      fill_q  <= '0;
      state_q <= FILL;
    end else if (en) begin
      hist_q <= hist_nx;
      if (det) begin
        state_q <= MATCH;
        // Non-overlapping: forget the matched bits by restarting the fill.
        fill_q  <= overlap ? fill_inc : '0;
      end else begin
        // Covers FILL->ARMED, MATCH->ARMED (history still full) and
        // MATCH->FILL (fill was restarted on the detecting edge).
        fill_q  <= fill_inc;
        state_q <= (fill_inc == FILL_MAX) ? ARMED : FILL;
      end
    end
  end

  assign Y = (state_q == MATCH);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (det),
    .clr   (cnt_clr),
    .cnt   (match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_moore.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_moore
// Four detector instances share one stimulus stream:
//   k=0 u2 : PAT_W=2, CNT_W=8
//   k=1 u3 : PAT_W=3, CNT_W=8
//   k=2 uc : PAT_W=2, CNT_W=2 (saturation)
//   k=3 u1 : PAT_W=1, CNT_W=8
// The reference model keeps the whole sampled stream plus, per instance, the
// index where collection (re)started; a match is "the last PAT_W bits since
// that index equal the pattern".
// -----------------------------------------------------------------------------
module tb_seq_detect_moore;

  logic       clk = 1'b0;
  logic       reset, en, A, overlap, pat_load, cnt_clr;
  logic [1:0] pat_in2;
  logic [2:0] pat_in3;
  logic [0:0] pat_in1;
  logic       y2, y3, yc, y1;
  logic [7:0] cnt2, cnt3, cnt1;
  logic [1:0] cntc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_detect_moore #(.PAT_W(2), .CNT_W(8), .RESET_PAT(2'b01)) u2 (
    .clk(clk), .reset(reset), .en(en), .A(A), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in2), .cnt_clr(cnt_clr),
    .Y(y2), .match_cnt(cnt2));

  seq_detect_moore #(.PAT_W(3), .CNT_W(8), .RESET_PAT(3'b001)) u3 (
    .clk(clk), .reset(reset), .en(en), .A(A), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in3), .cnt_clr(cnt_clr),
    .Y(y3), .match_cnt(cnt3));

  seq_detect_moore #(.PAT_W(2), .CNT_W(2), .RESET_PAT(2'b01)) uc (
    .clk(clk), .reset(reset), .en(en), .A(A), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in2), .cnt_clr(cnt_clr),
    .Y(yc), .match_cnt(cntc));

  seq_detect_moore #(.PAT_W(1), .CNT_W(8), .RESET_PAT(1'b1)) u1 (
    .clk(clk), .reset(reset), .en(en), .A(A), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in1), .cnt_clr(cnt_clr),
    .Y(y1), .match_cnt(cnt1));

  logic       y_all   [4];
  logic [7:0] cnt_all [4];
  assign y_all   = '{y2, y3, yc, y1};
  assign cnt_all = '{cnt2, cnt3, {6'b0, cntc}, cnt1};

  // ---------------- reference model ----------------
  int m_w   [4] = '{2, 3, 2, 1};
  int m_max [4] = '{255, 255, 3, 255};
  int m_pat [4];
  int m_st  [4];
  int m_cnt [4];
  bit m_y   [4];
  bit strm  [$];

  function automatic int pat_for(int k);
    case (k)
      1:       return int'(pat_in3);
      3:       return int'(pat_in1);
      default: return int'(pat_in2);
    endcase
  endfunction

  function automatic bit tail_matches(int k);
    int v = 0;
    int n = strm.size();
    if (n - m_st[k] < m_w[k]) return 1'b0;
    for (int i = n - m_w[k]; i < n; i++) v = v * 2 + int'(strm[i]);
    return v == m_pat[k];
  endfunction

  // Advance the model with the inputs currently applied, then take the edge.
  task automatic clock_edge();
    bit det;
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        m_pat[k] = 1;
        m_st[k]  = strm.size();
        m_y[k]   = 1'b0;
        m_cnt[k] = 0;
      end
    end else begin
      if (!pat_load && en) strm.push_back(A);
      for (int k = 0; k < 4; k++) begin
        det = 1'b0;
        if (pat_load) begin
          m_pat[k] = pat_for(k);
          m_st[k]  = strm.size();
          m_y[k]   = 1'b0;
        end else if (en) begin
          det    = tail_matches(k);
          m_y[k] = det;
          if (det && !overlap) m_st[k] = strm.size();
        end
        if (cnt_clr) m_cnt[k] = 0;
        else if (det && m_cnt[k] < m_max[k]) m_cnt[k]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input bit a);
    A  = a;
    en = 1'b1;
    clock_edge();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clock_edge();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (y_all[k] !== 1'b0) begin
        n_fail++; $display("FAIL reset_y[%0d]: got %b expected 0", k, y_all[k]);
      end
      n_tests++;
      if (cnt_all[k] !== 8'd0) begin
        n_fail++; $display("FAIL reset_cnt[%0d]: got %0d expected 0", k, cnt_all[k]);
      end
    end
  endtask

  task automatic test_overlap_basic();
    bit stim [8] = '{0, 1, 0, 0, 1, 1, 0, 1};
    bit expy [8] = '{0, 1, 0, 0, 1, 0, 0, 1};
    do_reset();
    overlap = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample(stim[i]);
      n_tests++;
      if (y2 !== expy[i]) begin
        n_fail++; $display("FAIL basic_y[%0d]: got %b expected %b", i, y2, expy[i]);
      end
    end
    en = 1'b0;
    n_tests++;
    if (cnt2 !== 8'd3) begin
      n_fail++; $display("FAIL basic_cnt: got %0d expected 3", cnt2);
    end
  endtask

  task automatic test_overlap_mode();
    bit stim [5]    = '{1, 0, 1, 0, 1};
    bit exp_ov [5]  = '{0, 0, 1, 0, 1};
    bit exp_nov [5] = '{0, 0, 1, 0, 0};
    for (int mode = 1; mode >= 0; mode--) begin
      do_reset();
      pat_in3  = 3'b101;
      pat_load = 1'b1;
      clock_edge();
      pat_load = 1'b0;
      overlap  = mode[0];
      for (int i = 0; i < 5; i++) begin
        sample(stim[i]);
        n_tests++;
        if (y3 !== (mode == 1 ? exp_ov[i] : exp_nov[i])) begin
          n_fail++; $display("FAIL ovl%0d_y[%0d]: got %b expected %b", mode, i, y3,
                             (mode == 1 ? exp_ov[i] : exp_nov[i]));
        end
      end
      en = 1'b0;
      n_tests++;
      if (cnt3 !== ((mode == 1) ? 8'd2 : 8'd1)) begin
        n_fail++; $display("FAIL ovl%0d_cnt: got %0d expected %0d", mode, cnt3,
                           (mode == 1) ? 2 : 1);
      end
    end
    overlap = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    overlap = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample(1'b0);
      sample(1'b1);
    end
    n_tests++;
    if (cntc !== 2'd3) begin
      n_fail++; $display("FAIL sat_cnt: got %0d expected 3", cntc);
    end
    n_tests++;
    if (cnt2 !== 8'd5) begin
      n_fail++; $display("FAIL sat_wide_cnt: got %0d expected 5", cnt2);
    end
    sample(1'b0);
    cnt_clr = 1'b1;
    sample(1'b1);
    cnt_clr = 1'b0;
    en      = 1'b0;
    n_tests++;
    if (cntc !== 2'd0 || cnt2 !== 8'd0) begin
      n_fail++; $display("FAIL clr_wins: got %0d/%0d expected 0/0", cntc, cnt2);
    end
    n_tests++;
    if (y2 !== 1'b1) begin
      n_fail++; $display("FAIL clr_y: got %b expected 1", y2);
    end
  endtask

  task automatic test_pat_load();
    do_reset();
    overlap = 1'b1;
    sample(1'b0);
    sample(1'b1);
    sample(1'b0);
    pat_in2  = 2'b10;
    pat_load = 1'b1;
    A        = 1'b1;
    en       = 1'b1;
    clock_edge();
    pat_load = 1'b0;
    n_tests++;
    if (y2 !== 1'b0 || cnt2 !== 8'd1) begin
      n_fail++; $display("FAIL load_edge: got y=%b cnt=%0d expected y=0 cnt=1", y2, cnt2);
    end
    sample(1'b1);
    n_tests++;
    if (y2 !== 1'b0) begin
      n_fail++; $display("FAIL load_s1: got %b expected 0", y2);
    end
    sample(1'b0);
    n_tests++;
    if (y2 !== 1'b1 || cnt2 !== 8'd2) begin
      n_fail++; $display("FAIL load_s2: got y=%b cnt=%0d expected y=1 cnt=2", y2, cnt2);
    end
    en      = 1'b0;
    pat_in2 = 2'b01;
  endtask

  task automatic test_enable_hold();
    do_reset();
    overlap = 1'b1;
    sample(1'b0);
    sample(1'b1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      A = 1'($urandom_range(0, 1));
      clock_edge();
      n_tests++;
      if (y2 !== 1'b1 || cnt2 !== 8'd1) begin
        n_fail++; $display("FAIL hold[%0d]: got y=%b cnt=%0d expected y=1 cnt=1", i, y2, cnt2);
      end
    end
    // Reset while matching, with every other control asserted.
    pat_in2  = 2'b10;
    pat_load = 1'b1;
    cnt_clr  = 1'b1;
    en       = 1'b1;
    A        = 1'b1;
    do_reset();
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
    pat_in2  = 2'b01;
    n_tests++;
    if (y2 !== 1'b0 || cnt2 !== 8'd0) begin
      n_fail++; $display("FAIL mid_reset: got y=%b cnt=%0d expected y=0 cnt=0", y2, cnt2);
    end
    sample(1'b0);
    sample(1'b1);
    en = 1'b0;
    n_tests++;
    if (y2 !== 1'b1) begin
      n_fail++; $display("FAIL reset_pat01: got %b expected 1", y2);
    end
  endtask

  task automatic test_pat_w1();
    bit b;
    int ones = 0;
    do_reset();
    overlap = 1'b0;
    for (int i = 0; i < 12; i++) begin
      b = 1'($urandom_range(0, 1));
      sample(b);
      ones += int'(b);
      n_tests++;
      if (y1 !== b || cnt1 !== 8'(ones)) begin
        n_fail++; $display("FAIL w1[%0d]: got y=%b cnt=%0d expected y=%b cnt=%0d",
                           i, y1, cnt1, b, ones);
      end
    end
    en      = 1'b0;
    overlap = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 199) == 0);
      en       = ($urandom_range(0, 3) != 0);
      A        = 1'($urandom_range(0, 1));
      pat_load = ($urandom_range(0, 39) == 0);
      cnt_clr  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) == 0) overlap = ~overlap;
      pat_in2  = 2'($urandom_range(0, 3));
      pat_in3  = 3'($urandom_range(0, 7));
      pat_in1  = 1'($urandom_range(0, 1));
      clock_edge();
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (y_all[k] !== m_y[k] || cnt_all[k] !== 8'(m_cnt[k])) begin
          n_fail++;
          $display("FAIL rand[%0d] dut%0d: got y=%b cnt=%0d expected y=%b cnt=%0d",
                   c, k, y_all[k], cnt_all[k], m_y[k], m_cnt[k]);
        end
      end
    end
    reset    = 1'b0;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
    en       = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    A        = 1'b0;
    overlap  = 1'b1;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
    pat_in2  = 2'b01;
    pat_in3  = 3'b101;
    pat_in1  = 1'b1;
    #2;
    test_reset();
    test_overlap_basic();
    test_overlap_mode();
    test_saturation();
    test_pat_load();
    test_enable_hold();
    test_pat_w1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
